// File: rtl/alu_branch_control_if.sv
// -----------------------------------------------------------------------------
// alu_branch_control_if
//   Bundles the ID-stage inputs and the registered EX-stage results of
//   alu_branch_control so that producer and consumer share one port.
//
//   ID-stage inputs (driven by master, read by slave):
//     instruction[31:0]   instruction word
//     pc[63:0]            PC of that instruction
//     rs1_data, rs2_data  64-bit register operands
//     immediate[63:0]     sign-extended immediate, pre-formatted per imm_type
//   Results (driven by slave, read by master):
//     mem_read, mem_write, reg_write, branch, alu_src_b_sel  registered controls
//     imm_type[2:0]       combinational immediate format (0=I 1=S 2=B 3=U)
//     alu_funct3, alu_funct7  registered ALU operation codes
//     alu_result[63:0], take_branch, branch_target[63:0]  registered results
// -----------------------------------------------------------------------------
interface alu_branch_control_if;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] immediate;

    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        alu_src_b_sel;
    logic [2:0]  imm_type;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic [63:0] alu_result;
    logic        take_branch;
    logic [63:0] branch_target;

    modport master (
        output instruction, pc, rs1_data, rs2_data, immediate,
        input  mem_read, mem_write, reg_write, branch, alu_src_b_sel,
        input  imm_type, alu_funct3, alu_funct7,
        input  alu_result, take_branch, branch_target
    );

    modport slave (
        input  instruction, pc, rs1_data, rs2_data, immediate,
        output mem_read, mem_write, reg_write, branch, alu_src_b_sel,
        output imm_type, alu_funct3, alu_funct7,
        output alu_result, take_branch, branch_target
    );
endinterface

// File: rtl/alu_branch_control.sv
// -----------------------------------------------------------------------------
// alu_branch_control
//   Single-stage RV64 decode + ALU + branch resolution. The instruction and
//   operands presented in one cycle appear as registered controls, ALU result,
//   branch decision and branch target in the next cycle. imm_type is the only
//   combinational output so the immediate generator upstream can format the
//   immediate in the same cycle.
//
//   Ports:
//     clk   sole clock, all state on the rising edge
//     rst   synchronous active-low reset; clears every registered output
//     bus   alu_branch_control_if.slave (see interface for signal list)
//
//   Configuration macro:
//     ALU_RV64W_EN  when defined, OP-IMM-32 (0011011) and OP-32 (0111011)
//                   execute as 32-bit word operations whose result is
//                   sign-extended from bit 31. When undefined both opcodes
//                   are treated as illegal.
// -----------------------------------------------------------------------------
module alu_branch_control (
    input  logic                 clk,
    input  logic                 rst,
    alu_branch_control_if.slave  bus
);

    // Major opcodes
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
`ifdef ALU_RV64W_EN
    localparam logic [6:0] OPC_IALU32 = 7'b0011011;
    localparam logic [6:0] OPC_R32    = 7'b0111011;
`endif

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_IALU    = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BRANCH  = 3'd5,
        CLS_R32     = 3'd6,
        CLS_IALU32  = 3'd7
    } op_class_e;

    // Instruction fields
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_in_s;
    logic [6:0]  funct7_in_s;

    // Decode results
    op_class_e   op_class_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        reg_write_s;
    logic        branch_s;
    logic        alu_src_b_sel_s;
    logic [2:0]  imm_type_s;
    logic [2:0]  alu_funct3_s;
    logic [6:0]  alu_funct7_s;

    // Datapath
    logic [63:0] op_a_s;
    logic [63:0] op_b_s;
    logic        is_r_form_s;
    logic        is_word_s;
    logic [63:0] alu64_s;
    logic [63:0] alu_result_s;
    logic        branch_cond_s;
    logic        take_branch_s;
    logic [63:0] branch_target_s;

    // Output registers
    logic        mem_read_r;
    logic        mem_write_r;
    logic        reg_write_r;
    logic        branch_r;
    logic        alu_src_b_sel_r;
    logic [2:0]  alu_funct3_r;
    logic [6:0]  alu_funct7_r;
    logic [63:0] alu_result_r;
    logic        take_branch_r;
    logic [63:0] branch_target_r;

    // Register-index and rd bits are not needed by this stage
    logic        unused_fields_s;
    assign unused_fields_s = ^{bus.instruction[24:15], bus.instruction[11:7]};

    assign opcode_s    = bus.instruction[6:0];
    assign funct3_in_s = bus.instruction[14:12];
    assign funct7_in_s = bus.instruction[31:25];

    // Opcode decode: controls, immediate format and the ALU operation codes
    always_comb begin
        op_class_s      = CLS_ILLEGAL;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        reg_write_s     = 1'b0;
        branch_s        = 1'b0;
        alu_src_b_sel_s = 1'b0;
        imm_type_s      = 3'd0;
        alu_funct3_s    = 3'b000;
        alu_funct7_s    = 7'b0000000;
        case (opcode_s)
            OPC_R: begin
                op_class_s   = CLS_R;
                reg_write_s  = 1'b1;
                alu_funct3_s = funct3_in_s;
                alu_funct7_s = funct7_in_s;
            end
            OPC_IALU: begin
                op_class_s      = CLS_IALU;
                reg_write_s     = 1'b1;
                alu_src_b_sel_s = 1'b1;
                imm_type_s      = IMM_I;
                alu_funct3_s    = funct3_in_s;
                // Only the right shifts carry an arithmetic/logical selector in bit 30
                if (funct3_in_s == 3'b101) begin
                    alu_funct7_s = {1'b0, bus.instruction[30], 5'b00000};
                end else begin
                    alu_funct7_s = 7'b0000000;
                end
            end
            OPC_LOAD: begin
                op_class_s      = CLS_LOAD;
                mem_read_s      = 1'b1;
                reg_write_s     = 1'b1;
                alu_src_b_sel_s = 1'b1;
                imm_type_s      = IMM_I;
            end
            OPC_STORE: begin
                op_class_s      = CLS_STORE;
                mem_write_s     = 1'b1;
                alu_src_b_sel_s = 1'b1;
                imm_type_s      = IMM_S;
            end
            OPC_BRANCH: begin
                op_class_s   = CLS_BRANCH;
                branch_s     = 1'b1;
                imm_type_s   = IMM_B;
                alu_funct3_s = funct3_in_s;
                alu_funct7_s = funct7_in_s;
            end
`ifdef ALU_RV64W_EN
            OPC_R32: begin
                op_class_s   = CLS_R32;
                reg_write_s  = 1'b1;
                alu_funct3_s = funct3_in_s;
                alu_funct7_s = funct7_in_s;
            end
            OPC_IALU32: begin
                op_class_s      = CLS_IALU32;
                reg_write_s     = 1'b1;
                alu_src_b_sel_s = 1'b1;
                imm_type_s      = IMM_I;
                alu_funct3_s    = funct3_in_s;
                if (funct3_in_s == 3'b101) begin
                    alu_funct7_s = {1'b0, bus.instruction[30], 5'b00000};
                end else begin
                    alu_funct7_s = 7'b0000000;
                end
            end
`endif
            default: begin
                op_class_s = CLS_ILLEGAL;
            end
        endcase
    end

    assign bus.imm_type = imm_type_s;

    // Operand selection; subtract is only meaningful for register-register forms
    assign op_a_s      = bus.rs1_data;
    assign op_b_s      = alu_src_b_sel_s ? bus.immediate : bus.rs2_data;
    assign is_r_form_s = (op_class_s == CLS_R) || (op_class_s == CLS_R32);
    assign is_word_s   = (op_class_s == CLS_R32) || (op_class_s == CLS_IALU32);

    // 64-bit ALU keyed by the decoded funct3/funct7
    always_comb begin
        alu64_s = 64'd0;
        case (alu_funct3_s)
            3'b000: begin
                if (alu_funct7_s[5] && is_r_form_s) begin
                    alu64_s = op_a_s - op_b_s;
                end else begin
                    alu64_s = op_a_s + op_b_s;
                end
            end
            3'b001: alu64_s = op_a_s << op_b_s[5:0];
            3'b010: alu64_s = {63'd0, ($signed(op_a_s) < $signed(op_b_s))};
            3'b011: alu64_s = {63'd0, (op_a_s < op_b_s)};
            3'b100: alu64_s = op_a_s ^ op_b_s;
            3'b101: begin
                if (alu_funct7_s[5]) begin
                    alu64_s = 64'($signed(op_a_s) >>> op_b_s[5:0]);
                end else begin
                    alu64_s = op_a_s >> op_b_s[5:0];
                end
            end
            3'b110: alu64_s = op_a_s | op_b_s;
            3'b111: alu64_s = op_a_s & op_b_s;
            default: alu64_s = 64'd0;
        endcase
    end

`ifdef ALU_RV64W_EN
    logic [31:0] a32_s;
    logic [31:0] b32_s;
    logic [31:0] alu32_s;

    assign a32_s = op_a_s[31:0];
    assign b32_s = op_b_s[31:0];

    // 32-bit word ALU; shifts take only five amount bits
    always_comb begin
        alu32_s = 32'd0;
        case (alu_funct3_s)
            3'b000: begin
                if (alu_funct7_s[5] && is_r_form_s) begin
                    alu32_s = a32_s - b32_s;
                end else begin
                    alu32_s = a32_s + b32_s;
                end
            end
            3'b001: alu32_s = a32_s << b32_s[4:0];
            3'b010: alu32_s = {31'd0, ($signed(a32_s) < $signed(b32_s))};
            3'b011: alu32_s = {31'd0, (a32_s < b32_s)};
            3'b100: alu32_s = a32_s ^ b32_s;
            3'b101: begin
                if (alu_funct7_s[5]) begin
                    alu32_s = 32'($signed(a32_s) >>> b32_s[4:0]);
                end else begin
                    alu32_s = a32_s >> b32_s[4:0];
                end
            end
            3'b110: alu32_s = a32_s | b32_s;
            3'b111: alu32_s = a32_s & b32_s;
            default: alu32_s = 32'd0;
        endcase
    end

    assign alu_result_s = is_word_s ? {{32{alu32_s[31]}}, alu32_s} : alu64_s;
`else
    logic unused_word_s;
    assign unused_word_s = is_word_s;
    assign alu_result_s  = alu64_s;
`endif

    // Branch condition compares the raw register operands, never the immediate
    always_comb begin
        branch_cond_s = 1'b0;
        case (funct3_in_s)
            3'b000:  branch_cond_s = (bus.rs1_data == bus.rs2_data);
            3'b001:  branch_cond_s = (bus.rs1_data != bus.rs2_data);
            3'b100:  branch_cond_s = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
            3'b101:  branch_cond_s = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
            3'b110:  branch_cond_s = (bus.rs1_data <  bus.rs2_data);
            3'b111:  branch_cond_s = (bus.rs1_data >= bus.rs2_data);
            default: branch_cond_s = 1'b0;
        endcase
    end

    // Target is produced every cycle so the fetch side never waits on the decision
    assign take_branch_s   = branch_s & branch_cond_s;
    assign branch_target_s = bus.pc + bus.immediate;

    // Output register stage; reset drops whatever was in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            reg_write_r     <= 1'b0;
            branch_r        <= 1'b0;
            alu_src_b_sel_r <= 1'b0;
            alu_funct3_r    <= 3'd0;
            alu_funct7_r    <= 7'd0;
            alu_result_r    <= 64'd0;
            take_branch_r   <= 1'b0;
            branch_target_r <= 64'd0;
        end else begin
            mem_read_r      <= mem_read_s;
            mem_write_r     <= mem_write_s;
            reg_write_r     <= reg_write_s;
            branch_r        <= branch_s;
            alu_src_b_sel_r <= alu_src_b_sel_s;
            alu_funct3_r    <= alu_funct3_s;
            alu_funct7_r    <= alu_funct7_s;
            alu_result_r    <= alu_result_s;
            take_branch_r   <= take_branch_s;
            branch_target_r <= branch_target_s;
        end
    end

    assign bus.mem_read      = mem_read_r;
    assign bus.mem_write     = mem_write_r;
    assign bus.reg_write     = reg_write_r;
    assign bus.branch        = branch_r;
    assign bus.alu_src_b_sel = alu_src_b_sel_r;
    assign bus.alu_funct3    = alu_funct3_r;
    assign bus.alu_funct7    = alu_funct7_r;
    assign bus.alu_result    = alu_result_r;
    assign bus.take_branch   = take_branch_r;
    assign bus.branch_target = branch_target_r;

endmodule

// File: tb/tb_alu_branch_control.sv
// -----------------------------------------------------------------------------
// tb_alu_branch_control
//   Directed vectors with hand-computed expectations. The driver pushes the
//   expected next-cycle response into a queue as it presents each vector; a
//   separate monitor pops and compares one cycle later.
// -----------------------------------------------------------------------------
module tb_alu_branch_control;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic vld = 1'b0;

    always #5 clk = ~clk;

    alu_branch_control_if bus ();

    alu_branch_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ctrl order: {mem_read, mem_write, reg_write, branch, alu_src_b_sel}
    localparam logic [4:0] C_NONE   = 5'b00000;
    localparam logic [4:0] C_R      = 5'b00100;
    localparam logic [4:0] C_I      = 5'b00101;
    localparam logic [4:0] C_LOAD   = 5'b10101;
    localparam logic [4:0] C_STORE  = 5'b01001;
    localparam logic [4:0] C_BRANCH = 5'b00010;

    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        int          id;
        logic [2:0]  imm_type;
        logic [4:0]  ctrl;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        chk_res;
        logic [63:0] res;
        logic        take;
        logic [63:0] tgt;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    function automatic exp_t mk(input int id, input logic [2:0] it, input logic [4:0] ctrl,
                                input logic [2:0] f3, input logic [6:0] f7, input logic chk_res,
                                input logic [63:0] res, input logic take, input logic [63:0] tgt);
        exp_t e;
        e.id = id; e.imm_type = it; e.ctrl = ctrl; e.f3 = f3; e.f7 = f7;
        e.chk_res = chk_res; e.res = res; e.take = take; e.tgt = tgt;
        return e;
    endfunction

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", id, name, act, exp);
        end
    endtask

    task automatic issue(input logic r, input logic [31:0] ins, input logic [63:0] pc,
                         input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                         input exp_t e);
        @(negedge clk);
        rst             = r;
        bus.instruction = ins;
        bus.pc          = pc;
        bus.rs1_data    = rs1;
        bus.rs2_data    = rs2;
        bus.immediate   = imm;
        vld             = 1'b1;
        sb_q.push_back(e);
    endtask

    // Monitor: one cycle after a vector is captured, compare against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (vld) begin
                #1;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: output seen with no expected entry");
                end else begin
                    e = sb_q.pop_front();
                    chk("imm_type", e.id, 64'(bus.imm_type), 64'(e.imm_type));
                    chk("ctrl", e.id, 64'({bus.mem_read, bus.mem_write, bus.reg_write,
                                           bus.branch, bus.alu_src_b_sel}), 64'(e.ctrl));
                    chk("alu_funct3", e.id, 64'(bus.alu_funct3), 64'(e.f3));
                    chk("alu_funct7", e.id, 64'(bus.alu_funct7), 64'(e.f7));
                    if (e.chk_res) chk("alu_result", e.id, bus.alu_result, e.res);
                    chk("take_branch", e.id, 64'(bus.take_branch), 64'(e.take));
                    chk("branch_target", e.id, bus.branch_target, e.tgt);
                end
            end
        end
    end

    initial begin
        bus.instruction = 32'd0;
        bus.pc          = 64'd0;
        bus.rs1_data    = 64'd0;
        bus.rs2_data    = 64'd0;
        bus.immediate   = 64'd0;

        // Reset state
        issue(1'b0, 32'h0000_0000, 64'h0, 64'h0, 64'h0, 64'h0, mk(0, 3'd0, C_NONE, 3'd0, 7'd0, 1'b1, 64'h0, 1'b0, 64'h0));
        // R-type: add, sub, slt, sltu, sll (shift amount from b[5:0]), sra
        issue(1'b1, 32'h0020_81B3, 64'h0, 64'd5, 64'd7, 64'h0, mk(1, 3'd0, C_R, 3'd0, 7'h00, 1'b1, 64'd12, 1'b0, 64'h0));
        issue(1'b1, 32'h4020_81B3, 64'h0, 64'd5, 64'd7, 64'h0, mk(2, 3'd0, C_R, 3'd0, 7'h20, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h0));
        issue(1'b1, 32'h0020_A1B3, 64'h0, M1, 64'd1, 64'h0, mk(3, 3'd0, C_R, 3'd2, 7'h00, 1'b1, 64'd1, 1'b0, 64'h0));
        issue(1'b1, 32'h0020_B1B3, 64'h0, M1, 64'd1, 64'h0, mk(4, 3'd0, C_R, 3'd3, 7'h00, 1'b1, 64'd0, 1'b0, 64'h0));
        issue(1'b1, 32'h0020_91B3, 64'h0, 64'd3, 64'h41, 64'h0, mk(5, 3'd0, C_R, 3'd1, 7'h00, 1'b1, 64'd6, 1'b0, 64'h0));
        issue(1'b1, 32'h4020_D1B3, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'h0, mk(6, 3'd0, C_R, 3'd5, 7'h20, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0));
        // Branches: beq taken / not taken, bne with target wrap, blt, bge, bltu, bgeu, funct3 010
        issue(1'b1, 32'h0020_8463, 64'h100, 64'd3, 64'd3, 64'd8, mk(7, 3'd2, C_BRANCH, 3'd0, 7'h00, 1'b1, 64'd6, 1'b1, 64'h108));
        issue(1'b1, 32'h0020_8463, 64'h100, 64'd3, 64'd4, 64'd8, mk(8, 3'd2, C_BRANCH, 3'd0, 7'h00, 1'b1, 64'd7, 1'b0, 64'h108));
        issue(1'b1, 32'h0020_9463, 64'hFFFF_FFFF_FFFF_FFF8, 64'd3, 64'd4, 64'h10, mk(9, 3'd2, C_BRANCH, 3'd1, 7'h00, 1'b1, 64'h30, 1'b1, 64'h8));
        issue(1'b1, 32'h0020_C463, 64'h40, M1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFC, mk(10, 3'd2, C_BRANCH, 3'd4, 7'h00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'h3C));
        issue(1'b1, 32'h0020_D463, 64'h40, M1, 64'd1, 64'd4, mk(11, 3'd2, C_BRANCH, 3'd5, 7'h00, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'h44));
        issue(1'b1, 32'h0020_E463, 64'h40, M1, 64'd1, 64'd4, mk(12, 3'd2, C_BRANCH, 3'd6, 7'h00, 1'b1, M1, 1'b0, 64'h44));
        issue(1'b1, 32'h0020_F463, 64'h40, M1, 64'd1, 64'd4, mk(13, 3'd2, C_BRANCH, 3'd7, 7'h00, 1'b1, 64'd1, 1'b1, 64'h44));
        issue(1'b1, 32'h0020_A463, 64'h40, 64'd3, 64'd3, 64'd4, mk(14, 3'd2, C_BRANCH, 3'd2, 7'h00, 1'b1, 64'd0, 1'b0, 64'h44));
        // I-ALU: addi -1, srai (bit 30 -> funct7), slli with bit 30 set (funct7 must stay 0)
        issue(1'b1, 32'hFFF0_8193, 64'h0, 64'd10, 64'd99, M1, mk(15, 3'd0, C_I, 3'd0, 7'h00, 1'b1, 64'd9, 1'b0, M1));
        issue(1'b1, 32'h4040_D193, 64'h0, 64'h8000_0000_0000_0000, 64'd0, 64'h404, mk(16, 3'd0, C_I, 3'd5, 7'h20, 1'b1, 64'hF800_0000_0000_0000, 1'b0, 64'h404));
        issue(1'b1, 32'h4030_9193, 64'h0, 64'd1, 64'd0, 64'h403, mk(17, 3'd0, C_I, 3'd1, 7'h00, 1'b1, 64'd8, 1'b0, 64'h403));
        // Load / store address add with forced funct3/funct7
        issue(1'b1, 32'h0100_B183, 64'h0, 64'h1000, 64'h77, 64'h10, mk(18, 3'd0, C_LOAD, 3'd0, 7'h00, 1'b1, 64'h1010, 1'b0, 64'h10));
        issue(1'b1, 32'h0020_B423, 64'h0, 64'h2000, 64'h55, 64'h8, mk(19, 3'd1, C_STORE, 3'd0, 7'h00, 1'b1, 64'h2008, 1'b0, 64'h8));
        // OP-32 addw
`ifdef ALU_RV64W_EN
        issue(1'b1, 32'h0020_81BB, 64'h0, 64'h7FFF_FFFF, 64'd1, 64'h0, mk(20, 3'd0, C_R, 3'd0, 7'h00, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0, 64'h0));
`else
        issue(1'b1, 32'h0020_81BB, 64'h0, 64'h7FFF_FFFF, 64'd1, 64'h0, mk(20, 3'd0, C_NONE, 3'd0, 7'h00, 1'b0, 64'h0, 1'b0, 64'h0));
`endif
        // Illegal opcode with all-ones funct fields; target still computed
        issue(1'b1, 32'hFE00_F07F, 64'h200, 64'd3, 64'd3, 64'd4, mk(21, 3'd0, C_NONE, 3'd0, 7'h00, 1'b0, 64'h0, 1'b0, 64'h204));
        // Mid-stream reset discards the in-flight result, then recovery
        issue(1'b1, 32'h0020_81B3, 64'h10, 64'd5, 64'd7, 64'd4, mk(22, 3'd0, C_R, 3'd0, 7'h00, 1'b1, 64'd12, 1'b0, 64'h14));
        issue(1'b0, 32'h0020_8463, 64'h100, 64'd3, 64'd3, 64'd8, mk(23, 3'd2, C_NONE, 3'd0, 7'h00, 1'b1, 64'h0, 1'b0, 64'h0));
        issue(1'b1, 32'h4020_81B3, 64'h0, 64'd5, 64'd7, 64'h0, mk(24, 3'd0, C_R, 3'd0, 7'h20, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h0));

        @(negedge clk);
        vld = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected responses never observed, required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_branch_control.md
ALU_BRANCH_CONTROL -- requirements
Module: alu_branch_control

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have ports: instruction  in  32  ID-stage instruction word.
REQ-004 SHALL have ports: pc  in  64  PC of instruction.
REQ-005 SHALL have ports: rs1_data, rs2_data  in  64 each  register operands.
REQ-006 SHALL have ports: immediate  in  64  sign-extended immediate, already formatted per imm_type.
REQ-007 SHALL have ports: mem_read, mem_write, reg_write, branch, alu_src_b_sel  out  1 each  registered controls.
REQ-008 SHALL have ports: imm_type  out  3  0=I, 1=S, 2=B, 3=U (reserved), combinational from instruction.
REQ-009 SHALL have ports: alu_funct3  out  3; alu_funct7  out  7  registered ALU operation codes.
REQ-010 SHALL have ports: alu_result  out  64; take_branch  out  1; branch_target  out  64  registered.

Function
REQ-011 SHALL register all outputs except imm_type; latency one clk from input to output.
REQ-012 SHALL decode opcode: 0110011 R (reg_write); 0010011 I-ALU (reg_write, alu_src_b_sel); 0000011 load (mem_read, reg_write, alu_src_b_sel); 0100011 store (mem_write, alu_src_b_sel); 1100011 branch (branch).
REQ-013 SHALL treat any other opcode as illegal: every control 0, alu_funct3/funct7 0, take_branch 0.
REQ-014 SHALL drive imm_type: I for I-ALU/load, S for store, B for branch, 0 otherwise.
REQ-015 SHALL force alu_funct3=000, alu_funct7=0 for load/store (address add).
REQ-016 SHALL, for I-ALU, pass funct3; alu_funct7 = {1'b0, instruction[30], 5'b0} only when funct3=101, else 0.
REQ-017 SHALL, for R and branch, pass instruction funct3 and funct7 unchanged.
REQ-018 SHALL select ALU operand b = immediate when alu_src_b_sel, else rs2_data.
REQ-019 SHALL compute by funct3: 000 add (sub if funct7[5] and R-type), 001 sll, 010 slt signed, 011 sltu, 100 xor, 101 srl (sra if funct7[5]), 110 or, 111 and.
REQ-020 SHALL use b[5:0] as shift amount; slt/sltu result is 0 or 1 zero-extended; add/sub wrap modulo 2^64.
REQ-021 SHALL evaluate branch on rs1_data/rs2_data: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu; 010/011 never taken.
REQ-022 SHALL set take_branch = branch AND condition; branch_target = pc + immediate (wrap modulo 2^64) every cycle regardless of take_branch.
REQ-023 SHALL still compute alu_result for branches (value unspecified to consumers, deterministic per REQ-019).

Reset
REQ-024 SHALL, while rst=0 at a rising edge, clear every registered output to 0; imm_type stays combinational.
REQ-025 SHALL, with rst deasserted, produce the instruction presented in the prior cycle; reset mid-stream discards the in-flight result.

Configuration
REQ-026 SHALL support macro ALU_RV64W_EN: defined, opcodes 0011011 (OP-IMM-32) and 0111011 (OP-32) decoded like I-ALU/R with 32-bit operation on low words, shifts use b[4:0], result sign-extended from bit 31; undefined, both opcodes illegal per REQ-013.

Verification
REQ-027 SHALL pass: instr 0x002081B3, rs1=5, rs2=7 -> next cycle alu_result=12, reg_write=1, others 0.
REQ-028 SHALL pass: instr 0x402081B3, rs1=5, rs2=7 -> alu_result=0xFFFFFFFFFFFFFFFE.
REQ-029 SHALL pass: instr 0x0020A1B3, rs1=-1, rs2=1 -> alu_result=1; same operands funct3 011 -> 0.
REQ-030 SHALL pass: instr 0x00208463, pc=0x100, imm=8, rs1=rs2=3 -> take_branch=1, branch_target=0x108, imm_type=2; rs2=4 -> take_branch=0.
REQ-031 SHALL pass: rst=0 for one edge after any valid instruction -> all registered outputs 0 next cycle.
REQ-032 SHALL pass: instr 0x002081BB, rs1=0x7FFFFFFF, rs2=1 -> with ALU_RV64W_EN alu_result=0xFFFFFFFF80000000; without, all controls 0.
